// File: rtl/rot_addr_sequencer.sv
// Address sequencer for one image-rotation job: walks source pixels in raster order and
// emits {read, write} byte-address commands to the DMA master over valid/ready.
module rot_addr_sequencer #(
    parameter int AW        = 32,
    parameter int DIM_W     = 12,
    parameter int PIX_SHIFT = 2
) (
    input  logic             I_HCLK,
    input  logic             I_HRESET,
    input  logic             I_START,
    input  logic             I_ABORT,
    input  logic [1:0]       I_MODE,
    input  logic [AW-1:0]    I_SRC_ADDR,
    input  logic [AW-1:0]    I_DST_ADDR,
    input  logic [DIM_W-1:0] I_WIDTH,
    input  logic [DIM_W-1:0] I_HEIGHT,
    output logic             O_CMD_VALID,
    input  logic             I_CMD_READY,
    output logic [AW-1:0]    O_CMD_RADDR,
    output logic [AW-1:0]    O_CMD_WADDR,
    output logic             O_CMD_LAST,
    output logic             O_BUSY,
    output logic             O_DONE,
    output logic             O_ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_COPY  = 2'd0,
        MODE_CW90  = 2'd1,
        MODE_R180  = 2'd2,
        MODE_CW270 = 2'd3
    } mode_e;

    localparam logic [DIM_W-1:0] DIM_ZERO  = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0] DIM_ONE   = DIM_W'(1);
    localparam logic [AW-1:0]    ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]    ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0]    PIX_BYTES = ADDR_ONE << PIX_SHIFT;

    // One-time setup product for the first destination offset; the per-pixel walk never multiplies.
    function automatic logic [AW-1:0] dim_mul(input logic [DIM_W-1:0] a, input logic [DIM_W-1:0] b);
        logic [AW-1:0] acc;
        acc = ADDR_ZERO;
        for (int i = 0; i < DIM_W; i++) begin
            if (b[i]) begin
                acc = acc + (AW'(a) << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [DIM_W-1:0] w_q, w_d;
    logic [DIM_W-1:0] h_q, h_d;
    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic [AW-1:0]    raddr_q, raddr_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [AW-1:0]    wrow_q, wrow_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [DIM_W-1:0] w_m1_s;
    logic [DIM_W-1:0] h_m1_s;
    logic [AW-1:0]    w_bytes_s;
    logic [AW-1:0]    h_bytes_s;
    logic [AW-1:0]    step_x_s;
    logic [AW-1:0]    step_y_s;
    logic [AW-1:0]    first_idx_s;
    logic             zero_dim_s;

    // Per-mode address steps: step_x moves along a source row, step_y moves between row starts.
    always_comb begin
        w_m1_s      = w_q - DIM_ONE;
        h_m1_s      = h_q - DIM_ONE;
        w_bytes_s   = AW'(w_q) << PIX_SHIFT;
        h_bytes_s   = AW'(h_q) << PIX_SHIFT;
        zero_dim_s  = (w_q == DIM_ZERO) || (h_q == DIM_ZERO);
        step_x_s    = PIX_BYTES;
        step_y_s    = w_bytes_s;
        first_idx_s = ADDR_ZERO;
        case (mode_q)
            MODE_COPY: begin
                step_x_s    = PIX_BYTES;
                step_y_s    = w_bytes_s;
                first_idx_s = ADDR_ZERO;
            end
            MODE_CW90: begin
                step_x_s    = h_bytes_s;
                step_y_s    = ADDR_ZERO - PIX_BYTES;
                first_idx_s = AW'(h_m1_s);
            end
            MODE_R180: begin
                step_x_s    = ADDR_ZERO - PIX_BYTES;
                step_y_s    = ADDR_ZERO - w_bytes_s;
                first_idx_s = dim_mul(w_q, h_q) - ADDR_ONE;
            end
            MODE_CW270: begin
                step_x_s    = ADDR_ZERO - h_bytes_s;
                step_y_s    = PIX_BYTES;
                first_idx_s = dim_mul(w_m1_s, h_q);
            end
            default: begin
                step_x_s    = PIX_BYTES;
                step_y_s    = w_bytes_s;
                first_idx_s = ADDR_ZERO;
            end
        endcase
    end

    // Next-state and next-output logic; abort outranks everything once a job has left IDLE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        w_d     = w_q;
        h_d     = h_q;
        x_d     = x_q;
        y_d     = y_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wrow_d  = wrow_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (I_ABORT && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_START && !I_ABORT) begin
                        mode_d  = mode_e'(I_MODE);
                        src_d   = I_SRC_ADDR;
                        dst_d   = I_DST_ADDR;
                        w_d     = I_WIDTH;
                        h_d     = I_HEIGHT;
                        state_d = S_LOAD;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    x_d     = DIM_ZERO;
                    y_d     = DIM_ZERO;
                    raddr_d = src_q;
                    waddr_d = dst_q + (first_idx_s << PIX_SHIFT);
                    wrow_d  = dst_q + (first_idx_s << PIX_SHIFT);
                    if (zero_dim_s) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        valid_d = 1'b1;
                        last_d  = (w_m1_s == DIM_ZERO) && (h_m1_s == DIM_ZERO);
                    end
                end
                S_RUN: begin
                    if (valid_q && I_CMD_READY) begin
                        if (last_q) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            raddr_d = raddr_q + PIX_BYTES;
                            if (x_q == w_m1_s) begin
                                x_d     = DIM_ZERO;
                                y_d     = y_q + DIM_ONE;
                                wrow_d  = wrow_q + step_y_s;
                                waddr_d = wrow_q + step_y_s;
                            end else begin
                                x_d     = x_q + DIM_ONE;
                                waddr_d = waddr_q + step_x_s;
                            end
                            last_d = (x_d == w_m1_s) && (y_d == h_m1_s);
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, latched job config, walk counters and registered outputs.
    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_COPY;
            src_q   <= ADDR_ZERO;
            dst_q   <= ADDR_ZERO;
            w_q     <= DIM_ZERO;
            h_q     <= DIM_ZERO;
            x_q     <= DIM_ZERO;
            y_q     <= DIM_ZERO;
            raddr_q <= ADDR_ZERO;
            waddr_q <= ADDR_ZERO;
            wrow_q  <= ADDR_ZERO;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wrow_q  <= wrow_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign O_CMD_VALID = valid_q;
    assign O_CMD_RADDR = raddr_q;
    assign O_CMD_WADDR = waddr_q;
    assign O_CMD_LAST  = last_q;
    assign O_BUSY      = busy_q;
    assign O_DONE      = done_q;
    assign O_ERR       = err_q;

endmodule

// File: tb/tb_rot_addr_sequencer.sv
// Scoreboard bench for rot_addr_sequencer: a pixel-formula model queues expected commands,
// a negedge monitor pops and compares every handshake and every done pulse.
module tb_rot_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort_s;
    logic [1:0]  mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [11:0] wid;
    logic [11:0] hgt;
    logic        ready;
    logic        valid;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic        last;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    rot_addr_sequencer #(.AW(32), .DIM_W(12), .PIX_SHIFT(2)) dut (
        .I_HCLK(clk), .I_HRESET(rst), .I_START(start), .I_ABORT(abort_s), .I_MODE(mode),
        .I_SRC_ADDR(src), .I_DST_ADDR(dst), .I_WIDTH(wid), .I_HEIGHT(hgt),
        .O_CMD_VALID(valid), .I_CMD_READY(ready), .O_CMD_RADDR(raddr), .O_CMD_WADDR(waddr),
        .O_CMD_LAST(last), .O_BUSY(busy), .O_DONE(done), .O_ERR(err)
    );

    typedef struct packed {
        logic [31:0] ra;
        logic [31:0] wa;
        logic        lst;
    } cmd_t;

    cmd_t exp_q[$];
    logic exp_err_q[$];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int ready_pct = 100;
    int pat_len = 0;
    int pat_i = 0;
    logic [4:0] ready_pat = 5'b10100;
    logic stall_prev = 1'b0;
    cmd_t held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each source pixel's destination index straight from the rotation formulas.
    task automatic push_job(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                            input int wv, input int hv);
        cmd_t c;
        logic [31:0] idx;
        logic [31:0] lin;
        if (wv == 0 || hv == 0) begin
            exp_err_q.push_back(1'b1);
            return;
        end
        for (int yy = 0; yy < hv; yy++) begin
            for (int xx = 0; xx < wv; xx++) begin
                lin = yy * wv + xx;
                case (m)
                    2'd0:    idx = yy * wv + xx;
                    2'd1:    idx = xx * hv + (hv - 1 - yy);
                    2'd2:    idx = (hv - 1 - yy) * wv + (wv - 1 - xx);
                    default: idx = (wv - 1 - xx) * hv + yy;
                endcase
                c.ra  = s + (lin << 2);
                c.wa  = d + (idx << 2);
                c.lst = (xx == wv - 1) && (yy == hv - 1);
                exp_q.push_back(c);
            end
        end
        exp_err_q.push_back(1'b0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: fixed pattern when one is loaded, otherwise random with ready_pct duty.
    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pat_len > 0) begin
                ready = ready_pat[pat_i % pat_len];
                pat_i++;
            end else begin
                ready = ($urandom_range(99) < ready_pct);
            end
        end
    end

    // Monitor: handshakes and done pulses are checked against the scoreboard queues.
    always @(negedge clk) begin
        cmd_t got;
        cmd_t e;
        logic e_err;
        if (rst || abort_s) begin
            stall_prev <= 1'b0;
        end else begin
            got.ra = raddr;
            got.wa = waddr;
            got.lst = last;
            if (stall_prev) begin
                check("stall_valid", valid, 1'b1);
                check("stall_raddr", got.ra, held.ra);
                check("stall_waddr", got.wa, held.wa);
                check("stall_last", got.lst, held.lst);
            end
            if (valid && ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_cmd", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_raddr", got.ra, e.ra);
                    check("cmd_waddr", got.wa, e.wa);
                    check("cmd_last", got.lst, e.lst);
                end
                if (got.lst) last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                if (exp_err_q.size() == 0) begin
                    check("extra_done", 1'b1, 1'b0);
                end else begin
                    e_err = exp_err_q.pop_front();
                    check("done_err", err, e_err);
                    if (!e_err) check("done_after_last", cyc, last_hs_cyc + 1);
                end
            end else if (err) begin
                check("err_without_done", 1'b1, 1'b0);
            end
            stall_prev <= valid && !ready;
            held <= got;
        end
    end

    task automatic start_job(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                             input int wv, input int hv);
        mode  = m;
        src   = s;
        dst   = d;
        wid   = wv[11:0];
        hgt   = hv[11:0];
        start = 1'b1;
        push_job(m, s, d, wv, hv);
        tick();
        start = 1'b0;
        mode  = 2'($urandom_range(3));
        src   = $urandom;
        dst   = $urandom;
        wid   = 12'($urandom_range(4095));
        hgt   = 12'($urandom_range(4095));
    endtask

    task automatic run_job(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                           input int wv, input int hv, input bit timing, input int abort_at);
        int base;
        bit aborted;
        base = done_cnt;
        aborted = 1'b0;
        start_job(m, s, d, wv, hv);
        if (timing) begin
            @(negedge clk);
            check("load_busy", busy, 1'b1);
            check("load_valid", valid, 1'b0);
            tick();
            @(negedge clk);
            if (wv == 0 || hv == 0) begin
                check("zero_done", done, 1'b1);
                check("zero_err", err, 1'b1);
                check("zero_valid", valid, 1'b0);
            end else begin
                check("first_valid", valid, 1'b1);
            end
        end
        for (int n = 0; n < 5000; n++) begin
            if (done_cnt != base) break;
            if (abort_at >= 0 && n == abort_at && busy) begin
                abort_s = 1'b1;
                tick();
                abort_s = 1'b0;
                exp_q.delete();
                exp_err_q.delete();
                @(negedge clk);
                check("abort_valid", valid, 1'b0);
                check("abort_busy", busy, 1'b0);
                aborted = 1'b1;
                break;
            end
            if (busy && $urandom_range(9) == 0) begin
                mode  = 2'($urandom_range(3));
                wid   = 12'($urandom_range(8));
                start = 1'b1;
                tick();
                start = 1'b0;
            end else begin
                tick();
            end
        end
        if (!aborted) begin
            check("job_done", done_cnt - base, 1);
            check("cmds_left", exp_q.size(), 0);
            if (done_cnt == base) begin
                exp_q.delete();
                exp_err_q.delete();
            end
        end
    endtask

    initial begin
        int base_hs;
        rst = 1'b1;
        start = 1'b0;
        abort_s = 1'b0;
        mode = 2'd0;
        src = 32'h0;
        dst = 32'h0;
        wid = 12'd0;
        hgt = 12'd0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_raddr", raddr, 32'h0);
        check("rst_waddr", waddr, 32'h0);
        check("rst_last", last, 1'b0);
        tick();

        ready_pct = 100;
        run_job(2'd1, 32'h1000, 32'h2000, 3, 2, 1'b1, -1);
        run_job(2'd2, 32'h1000, 32'h2000, 3, 2, 1'b1, -1);
        run_job(2'd3, 32'h1000, 32'h0, 2, 2, 1'b1, -1);
        run_job(2'd0, 32'h1000, 32'h0, 2, 2, 1'b1, -1);

        pat_i = 0;
        pat_len = 5;
        run_job(2'd1, 32'h1000, 32'h2000, 3, 2, 1'b1, -1);
        pat_len = 0;

        run_job(2'd0, 32'h1000, 32'h2000, 0, 5, 1'b1, -1);
        run_job(2'd2, 32'h1000, 32'h2000, 7, 0, 1'b1, -1);
        run_job(2'd3, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 1, 1, 1'b1, -1);

        // Abort after the third handshake, then restart one cycle later.
        ready_pct = 100;
        base_hs = hs_cnt;
        start_job(2'd1, 32'h1000, 32'h2000, 3, 2);
        for (int n = 0; n < 50; n++) begin
            if (hs_cnt - base_hs >= 3) break;
            tick();
        end
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
        @(negedge clk);
        check("abort3_valid", valid, 1'b0);
        check("abort3_busy", busy, 1'b0);
        check("abort3_done", done, 1'b0);
        check("abort3_hs", hs_cnt - base_hs, 3);
        run_job(2'd1, 32'h1000, 32'h2000, 3, 2, 1'b1, -1);

        // Abort together with start in IDLE: no job may begin.
        mode = 2'd0;
        wid = 12'd2;
        hgt = 12'd2;
        start = 1'b1;
        abort_s = 1'b1;
        tick();
        start = 1'b0;
        abort_s = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("abort_start_busy", busy, 1'b0);
            check("abort_start_valid", valid, 1'b0);
            tick();
        end

        // Reset in the middle of a job.
        ready_pct = 50;
        start_job(2'd2, 32'h4000, 32'h8000, 4, 4);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
        @(negedge clk);
        check("midrst_valid", valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_raddr", raddr, 32'h0);
        check("midrst_waddr", waddr, 32'h0);
        check("midrst_last", last, 1'b0);
        tick();

        run_job(2'd0, 32'h100, 32'h200, 40, 3, 1'b0, -1);

        for (int j = 0; j < 40; j++) begin
            ready_pct = 30 + $urandom_range(70);
            run_job(2'($urandom_range(3)), $urandom, $urandom,
                    ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 6),
                    $urandom_range(1, 6), 1'($urandom_range(1)),
                    ($urandom_range(4) == 0) ? $urandom_range(12) : -1);
            if ($urandom_range(1) == 0) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
